flex_counter_ud: RTL and testbench
==================================

FLEX_COUNTER_UD -- requirements
Module: flex_counter_ud

Interface
REQ-001 Parameter NUM_CNT_BITS, default 4, counter width in bits, SHALL be >= 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 n_rst  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 clear  input  1  synchronous clear of the count.
REQ-005 load  input  1  synchronous parallel load.
REQ-006 load_val  input  NUM_CNT_BITS  value loaded when load is honoured.
REQ-007 count_enable  input  1  advance the count by one step.
REQ-008 count_down  input  1  direction: 0 = up, 1 = down.
REQ-009 stop_at_term  input  1  1 = saturate at the terminal value, 0 = wrap.
REQ-010 rollover_val  input  NUM_CNT_BITS  upper bound of the count range 1..rollover_val.
REQ-011 count_out  output  NUM_CNT_BITS  registered count.
REQ-012 rollover_flag  output  1  registered; high while count_out equals the terminal value.
REQ-013 wrap_pulse  output  1  registered one-cycle pulse marking a wrap.

Function
REQ-014 The terminal value SHALL be rollover_val when count_down=0 and 1 when count_down=1.
REQ-015 Next-count priority SHALL be: clear (next=0), then load (next=load_val), then count_enable, then hold.
REQ-016 Up step: if count_out >= rollover_val, next SHALL be 1 (wrap); otherwise next SHALL be count_out+1.
REQ-017 Down step: if count_out <= 1 or count_out > rollover_val, next SHALL be rollover_val (wrap); otherwise next SHALL be count_out-1.
REQ-018 With stop_at_term=1 and count_out equal to the terminal value, an enabled step SHALL hold count_out and SHALL NOT wrap.
REQ-019 With rollover_val=0, an enabled step SHALL hold count_out; clear and load SHALL still act.
REQ-020 Each update SHALL set rollover_flag to (next count == terminal value) and (rollover_val != 0), using the count_down sampled at the same edge.
REQ-021 Each update SHALL set wrap_pulse to 1 only when that edge performs a wrap per REQ-016/REQ-017, and to 0 otherwise; clear and load SHALL never set it.
REQ-022 Arithmetic SHALL be unsigned at NUM_CNT_BITS; no intermediate value SHALL overflow the range 0..2^NUM_CNT_BITS-1.
REQ-023 load_val SHALL be loaded unchecked, including values above rollover_val; the next enabled step then follows REQ-016/REQ-017.
REQ-024 A change of count_down SHALL take effect on the next enabled step, with no extra latency.
REQ-025 Latency from an input change to a visible output SHALL be exactly one clk edge.

Reset
REQ-026 When n_rst=0 at a rising edge, count_out SHALL become 0, and rollover_flag and wrap_pulse SHALL become 0, regardless of all other inputs.
REQ-027 Reset SHALL NOT act asynchronously; an n_rst pulse between edges SHALL have no effect.
REQ-028 Reset asserted mid-count SHALL discard the count; after release, counting SHALL restart from 0 (first up step gives 1).

Verification (NUM_CNT_BITS=4)
REQ-029 Reset: count_out=7, n_rst=0 for one edge with count_enable=1 -> count_out=0, rollover_flag=0, wrap_pulse=0; an n_rst glitch between edges -> no change.
REQ-030 Up wrap: rollover_val=5, after clear, count_enable=1 for 7 edges -> count_out 1,2,3,4,5,1,2; rollover_flag high only at 5; wrap_pulse high only at the second 1.
REQ-031 Down wrap: rollover_val=3, load 2, then count_down=1 enabled for 4 edges -> count_out 1,3,2,1; rollover_flag high at each 1; wrap_pulse high at 3.
REQ-032 Saturate: stop_at_term=1, rollover_val=4, up from 0 for 6 edges -> count_out 1,2,3,4,4,4; rollover_flag stays 1 from the first 4; wrap_pulse never asserted.
REQ-033 Priority and out of range:
- clear=load=count_enable=1 with load_val=9 -> count_out=0.
- Then load 9 with rollover_val=5 -> count_out=9, wrap_pulse=0.
- Then one up step -> count_out=1, wrap_pulse=1.
REQ-034 Zero bound: rollover_val=0, count_out=6, count_enable=1 for 3 edges -> count_out stays 6, rollover_flag=0; load 2 -> count_out=2.

Source files
------------

// File: rtl/flex_counter_ud.sv
// Up/down counter over the range 1..rollover_val with selectable wrap or saturate
// behaviour, parallel load, clear, a terminal-value flag and a one-cycle wrap pulse.
module flex_counter_ud #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    count_enable,
    input  logic                    count_down,
    input  logic                    stop_at_term,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    wrap_pulse
);

    localparam logic [NUM_CNT_BITS-1:0] ONE  = NUM_CNT_BITS'(1);
    localparam logic [NUM_CNT_BITS-1:0] ZERO = '0;

    logic [NUM_CNT_BITS-1:0] term_val;
    logic [NUM_CNT_BITS-1:0] next_count;
    logic                    next_wrap;
    logic                    at_term;
    logic                    zero_bound;

    assign term_val   = count_down ? ONE : rollover_val;
    assign at_term    = (count_out == term_val);
    assign zero_bound = (rollover_val == ZERO);

    always_comb begin
        next_count = count_out;
        next_wrap  = 1'b0;
        if (clear) begin
            next_count = ZERO;
        end else if (load) begin
            next_count = load_val;
        end else if (count_enable && !zero_bound && !(stop_at_term && at_term)) begin
            // Out-of-range counts (e.g. from an unchecked load) wrap like the terminal value.
            if (!count_down) begin
                if (count_out >= rollover_val) begin
                    next_count = ONE;
                    next_wrap  = 1'b1;
                end else begin
                    next_count = count_out + ONE;
                end
            end else begin
                if ((count_out <= ONE) || (count_out > rollover_val)) begin
                    next_count = rollover_val;
                    next_wrap  = 1'b1;
                end else begin
                    next_count = count_out - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count_out     <= ZERO;
            rollover_flag <= 1'b0;
            wrap_pulse    <= 1'b0;
        end else begin
            count_out     <= next_count;
            rollover_flag <= (next_count == term_val) && !zero_bound;
            wrap_pulse    <= next_wrap;
        end
    end

endmodule

// File: tb/tb_flex_counter_ud.sv
// Randomized and directed bench for flex_counter_ud against an integer reference model.
module tb_flex_counter_ud;

    localparam int N = 4;
    localparam int W = N + 2;

    logic         clk;
    logic         n_rst;
    logic         clear;
    logic         load;
    logic [N-1:0] load_val;
    logic         count_enable;
    logic         count_down;
    logic         stop_at_term;
    logic [N-1:0] rollover_val;
    logic [N-1:0] count_out;
    logic         rollover_flag;
    logic         wrap_pulse;

    int total = 0;
    int bad   = 0;

    int m_cnt  = 0;
    int m_flag = 0;
    int m_wrap = 0;

    logic [W-1:0] exp_q[$];

    flex_counter_ud #(.NUM_CNT_BITS(N)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .load         (load),
        .load_val     (load_val),
        .count_enable (count_enable),
        .count_down   (count_down),
        .stop_at_term (stop_at_term),
        .rollover_val (rollover_val),
        .count_out    (count_out),
        .rollover_flag(rollover_flag),
        .wrap_pulse   (wrap_pulse)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        n_rst = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0;
        count_enable = 1'b0; count_down = 1'b0; stop_at_term = 1'b0; rollover_val = '0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference model: the count lives in 1..rv; stepping past either end lands on the other.
    task automatic model_step(input bit rst, input bit clr, input bit ld, input int lv,
                              input bit en, input bit dn, input bit sat, input int rv);
        int term;
        int nxt;
        int wr;
        term = dn ? 1 : rv;
        nxt  = m_cnt;
        wr   = 0;
        if (!rst) begin
            m_cnt = 0; m_flag = 0; m_wrap = 0;
            return;
        end
        if (clr) nxt = 0;
        else if (ld) nxt = lv;
        else if (en && rv != 0 && !(sat && m_cnt == term)) begin
            if (!dn) begin
                if (m_cnt + 1 <= rv) nxt = m_cnt + 1;
                else begin nxt = 1; wr = 1; end
            end else begin
                if (m_cnt - 1 >= 1 && m_cnt <= rv) nxt = m_cnt - 1;
                else begin nxt = rv; wr = 1; end
            end
        end
        m_cnt  = nxt;
        m_flag = (nxt == term && rv != 0) ? 1 : 0;
        m_wrap = wr;
    endtask

    // driver: one clock edge with the given inputs, scoreboarded against the model
    task automatic apply(input bit rst, input bit clr, input bit ld, input int lv,
                         input bit en, input bit dn, input bit sat, input int rv);
        logic [W-1:0] e;
        logic [31:0]  lv_v;
        logic [31:0]  rv_v;
        lv_v = lv;
        rv_v = rv;
        @(negedge clk);
        n_rst = rst; clear = clr; load = ld; load_val = lv_v[N-1:0];
        count_enable = en; count_down = dn; stop_at_term = sat; rollover_val = rv_v[N-1:0];
        @(posedge clk);
        model_step(rst, clr, ld, lv, en, dn, sat, rv);
        exp_q.push_back({m_cnt[N-1:0], m_flag[0], m_wrap[0]});
        #1;
        e = exp_q.pop_front();
        check("sb_count", 32'(count_out), 32'(e[W-1:2]));
        check("sb_flag", 32'(rollover_flag), 32'(e[1]));
        check("sb_wrap", 32'(wrap_pulse), 32'(e[0]));
    endtask

    task automatic expect_out(input string tag, input int c, input int f, input int w);
        check({tag, "_count"}, 32'(count_out), c);
        check({tag, "_flag"}, 32'(rollover_flag), f);
        check({tag, "_wrap"}, 32'(wrap_pulse), w);
    endtask

    initial begin
        int c30[7];
        int f30[7];
        int w30[7];
        int c31[4];
        int w31[4];
        int c32[6];
        bit r_rst, r_clr, r_ld, r_en, r_dn, r_sat;
        int r_lv, r_rv;

        c30 = '{1, 2, 3, 4, 5, 1, 2};
        f30 = '{0, 0, 0, 0, 1, 0, 0};
        w30 = '{0, 0, 0, 0, 0, 1, 0};
        c31 = '{1, 3, 2, 1};
        w31 = '{0, 1, 0, 0};
        c32 = '{1, 2, 3, 4, 4, 4};

        apply(0, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("reset", 0, 0, 0);

        // reset mid-count, then glitch between edges
        apply(1, 0, 1, 7, 0, 0, 0, 10);
        expect_out("load7", 7, 0, 0);
        apply(0, 0, 0, 0, 1, 0, 0, 10);
        expect_out("rst_mid", 0, 0, 0);
        apply(1, 0, 0, 0, 1, 0, 0, 10);
        expect_out("restart", 1, 0, 0);
        apply(1, 0, 1, 7, 0, 0, 0, 10);
        #1 n_rst = 1'b0;
        #1 n_rst = 1'b1;
        #1 check("glitch_between", 32'(count_out), 7);
        apply(1, 0, 0, 0, 0, 0, 0, 10);
        expect_out("glitch_edge", 7, 0, 0);

        // up wrap
        apply(1, 1, 0, 0, 0, 0, 0, 5);
        for (int i = 0; i < 7; i++) begin
            apply(1, 0, 0, 0, 1, 0, 0, 5);
            expect_out($sformatf("upwrap%0d", i), c30[i], f30[i], w30[i]);
        end

        // down wrap
        apply(1, 0, 1, 2, 0, 0, 0, 3);
        for (int i = 0; i < 4; i++) begin
            apply(1, 0, 0, 0, 1, 1, 0, 3);
            expect_out($sformatf("dnwrap%0d", i), c31[i], (c31[i] == 1) ? 1 : 0, w31[i]);
        end

        // saturate
        apply(1, 1, 0, 0, 0, 0, 1, 4);
        for (int i = 0; i < 6; i++) begin
            apply(1, 0, 0, 0, 1, 0, 1, 4);
            expect_out($sformatf("sat%0d", i), c32[i], (c32[i] == 4) ? 1 : 0, 0);
        end

        // priority and out-of-range load
        apply(1, 1, 1, 9, 1, 0, 0, 5);
        expect_out("prio", 0, 0, 0);
        apply(1, 0, 1, 9, 0, 0, 0, 5);
        expect_out("load_oor", 9, 0, 0);
        apply(1, 0, 0, 0, 1, 0, 0, 5);
        expect_out("step_oor", 1, 0, 1);

        // zero bound
        apply(1, 0, 1, 6, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            apply(1, 0, 0, 0, 1, 0, 0, 0);
            expect_out($sformatf("zero%0d", i), 6, 0, 0);
        end
        apply(1, 0, 1, 2, 0, 0, 0, 0);
        expect_out("zero_load", 2, 0, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            r_rst = ($urandom_range(0, 39) != 0);
            r_clr = ($urandom_range(0, 15) == 0);
            r_ld  = ($urandom_range(0, 7) == 0);
            r_en  = ($urandom_range(0, 3) != 0);
            r_dn  = ($urandom_range(0, 1) == 1);
            r_sat = ($urandom_range(0, 2) == 0);
            r_lv  = $urandom_range(0, (1 << N) - 1);
            r_rv  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, (1 << N) - 1);
            apply(r_rst, r_clr, r_ld, r_lv, r_en, r_dn, r_sat, r_rv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
